// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the L1 cache's line-wide physical-memory port to a narrower,
//   burst-oriented main-memory port. A line write is sent as BEATS beats
//   (lowest word first). A line read is reassembled from BEATS beats. Each
//   line operation ends with a single-cycle resp_o to the cache.
//
// Ports
//   clk, rst    clock; synchronous active-low reset
//   line_i      line to write, captured when a write is accepted
//   line_o      assembled read line (valid from the resp_o cycle)
//   address_i   line address from the cache
//   read_i      cache fill request (level, held until resp_o)
//   write_i     cache write-back request (level, held until resp_o)
//   resp_o      one-cycle completion pulse to the cache
//   burst_i     read beat from memory
//   burst_o     write beat to memory
//   address_o   line-aligned memory address
//   read_o      memory read request
//   write_o     memory write request
//   resp_i      memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
  parameter  int BURST_W = 64,
  parameter  int BEATS   = 4,
  localparam int LINE_W  = BURST_W * BEATS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int               CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte-offset bits inside one line; these are zeroed on the memory address.
  localparam int               OFS_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [31:0]                     addr_q, addr_d;
  logic [BEATS-1:0][BURST_W-1:0]   wline_q, wline_d;
  logic [BEATS-1:0][BURST_W-1:0]   rline_q, rline_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;   // partial fill data is dropped
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state_q)
      IDLE: begin
        // Write-back has priority so the victim line leaves before the fill;
        // a concurrent read stays pending and is taken on a later IDLE cycle.
        if (write_i) begin
          addr_d  = {address_i[31:OFS_W], {OFS_W{1'b0}}};
          wline_d = line_i;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = {address_i[31:OFS_W], {OFS_W{1'b0}}};
          state_d = RD;
        end
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          rline_d[cnt_q] = burst_i;
          // The counter holds on the last beat and is cleared in DONE, so it
          // never wraps by overflow.
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      WR: begin
        write_o = 1'b1;
        burst_o = wline_q[cnt_q];
        if (resp_i) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Requests still held high here belong to the finished operation and
        // are not re-accepted; acceptance happens only in IDLE.
        resp_o  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign address_o = addr_q;
  assign line_o    = rline_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor. A transaction-level model (current line
// operation, beats completed, expected line contents) predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_cacheline_adaptor;
  localparam int BW = 64, BEATS = 4, LW = BW * BEATS;
  typedef logic [BEATS-1:0][BW-1:0] line_t;

  logic          clk = 1'b0;
  logic          rst;
  line_t         line_i;
  logic [LW-1:0] line_o;
  logic [31:0]   address_i, address_o;
  logic          read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [BW-1:0] burst_i, burst_o;

  always #5 clk = ~clk;

  cacheline_adaptor #(.BURST_W(BW), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Model: 0 = no line op, 1 = fill in progress, 2 = write-back in progress
  int          m_kind = 0, m_done_kind = 0, m_beats = 0;
  bit          m_done = 0, m_rst = 1;
  logic [31:0] m_addr = '0;
  line_t       m_wline = '0, m_line = '0;

  // Cache side
  bit          c_rd = 0, c_wr = 0, scramble = 0;
  logic [31:0] c_raddr = '0, c_waddr = '0;
  line_t       c_wline = '0;
  int          drop_kind = 0, n_resp = 0;

  // Memory side: optional resp_i pattern and read data queues
  bit          mp[$];
  logic [BW-1:0] md[$];
  logic [BW-1:0] wseq[$];
  bit          stray = 0;
  int          n_rdcyc = 0, n_wrcyc = 0;
  logic [31:0] seen_addr = '0;

  function automatic line_t rnd_line();
    line_t l;
    for (int j = 0; j < BEATS; j++) l[j] = {$urandom, $urandom};
    return l;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc();
    // check current outputs against the model
    if (m_rst) begin
      chk("rst_address_o", address_o, 0);
      chk("rst_burst_o", burst_o, 0);
    end
    chk("read_o", read_o, m_kind == 1);
    chk("write_o", write_o, m_kind == 2);
    chk("resp_o", resp_o, m_done);
    chk("line_o", line_o, m_line);
    if (m_kind != 0) chk("address_o", address_o, m_addr);
    if (m_kind == 2) chk("burst_o", burst_o, m_wline[m_beats]);
    if (read_o) begin n_rdcyc++; seen_addr = address_o; end
    if (write_o) n_wrcyc++;

    // cache: hold request through the resp_o cycle, drop it one cycle later
    if (drop_kind == 1) c_rd = 0;
    else if (drop_kind == 2) c_wr = 0;
    drop_kind = 0;
    if (resp_o) begin n_resp++; drop_kind = m_done_kind; end
    read_i    = c_rd;
    write_i   = c_wr;
    address_i = c_wr ? c_waddr : c_raddr;
    line_i    = c_wline;
    if (scramble && m_kind != 0) begin
      address_i = $urandom;
      line_i    = rnd_line();
    end

    // memory
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    if (read_o || write_o) begin
      if (mp.size() > 0) resp_i = mp.pop_front();
      else resp_i = ($urandom_range(0, 9) < 6);
      if (resp_i && read_o && md.size() > 0) burst_i = md.pop_front();
      if (resp_i && write_o) wseq.push_back(burst_o);
    end else if (stray) begin
      resp_i = ($urandom_range(0, 3) == 0);
    end

    // model: what the coming rising edge does
    m_rst = 0;
    if (!rst) begin
      m_kind = 0; m_done = 0; m_beats = 0; m_line = '0; m_rst = 1;
    end else if (m_kind != 0) begin
      if (resp_i) begin
        if (m_kind == 1) m_line[m_beats] = burst_i;
        m_beats++;
        if (m_beats == BEATS) begin
          m_done = 1; m_done_kind = m_kind; m_kind = 0;
        end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (write_i) begin
      m_kind = 2; m_addr = address_i & 32'hFFFF_FFE0; m_wline = line_i; m_beats = 0;
    end else if (read_i) begin
      m_kind = 1; m_addr = address_i & 32'hFFFF_FFE0; m_beats = 0;
    end
    @(negedge clk);
  endtask

  // Cycles until resp_o is seen (at least one cycle is always run).
  task automatic run_op(output int lat);
    lat = 0;
    do begin cyc(); lat++; end while (!resp_o && lat < 200);
  endtask

  initial begin
    line_t e;
    int    lat, r0, w0, i;
    rst = 1'b0; read_i = 0; write_i = 0; address_i = '0; line_i = '0;
    resp_i = 0; burst_i = '0;
    @(negedge clk);
    cyc();              // reset values
    rst = 1'b1;
    repeat (2) cyc();

    // Fill, memory waits 3 cycles before the first beat
    e[0] = {8{8'hA0}}; e[1] = {8{8'hB1}}; e[2] = {8{8'hC2}}; e[3] = {8{8'hD3}};
    mp = '{0, 0, 0, 1, 1, 1, 1};
    for (int j = 0; j < BEATS; j++) md.push_back(e[j]);
    c_rd = 1; c_raddr = 32'h1234_5678;
    r0 = n_rdcyc;
    run_op(lat);
    chk("t1_latency", lat, 8);
    chk("t1_address_o", seen_addr, 32'h1234_5660);
    chk("t1_read_o_cycles", n_rdcyc - r0, 7);
    chk("t1_line_o", line_o, e);
    repeat (2) cyc();
    // read_i was held through DONE; no second fill may follow
    r0 = n_rdcyc;
    repeat (6) cyc();
    chk("held_req_no_reread", n_rdcyc - r0, 0);

    // Write-back, four back-to-back beats
    mp = '{1, 1, 1, 1};
    wseq.delete();
    c_wr = 1; c_waddr = 32'h0000_ABCD; c_wline = {64'h4, 64'h3, 64'h2, 64'h1};
    w0 = n_wrcyc;
    run_op(lat);
    chk("t2_latency", lat, 5);
    chk("t2_write_o_cycles", n_wrcyc - w0, 4);
    chk("t2_nbeats", wseq.size(), 4);
    for (int j = 0; j < wseq.size() && j < 4; j++) chk("t2_burst_seq", wseq[j], j + 1);
    chk("t2_line_o_kept", line_o, e);
    repeat (2) cyc();

    // Fill with stalls 1,0,0,1,1,0,1
    mp = '{1, 0, 0, 1, 1, 0, 1};
    c_rd = 1; c_raddr = 32'h8000_0044;
    r0 = n_rdcyc;
    run_op(lat);
    chk("t3_latency", lat, 8);
    chk("t3_read_o_cycles", n_rdcyc - r0, 7);
    repeat (2) cyc();

    // Write-back and fill raised together
    e[0] = 64'h1111; e[1] = 64'h2222; e[2] = 64'h3333; e[3] = 64'h4444;
    mp = '{1, 1, 1, 1, 1, 1, 1, 1};
    for (int j = 0; j < BEATS; j++) md.push_back(e[j]);
    c_wr = 1; c_waddr = 32'h0000_1000; c_wline = rnd_line();
    c_rd = 1; c_raddr = 32'h0000_2020;
    run_op(lat);
    chk("t4_write_first", write_o, 0);
    chk("t4_lat1", lat, 5);
    run_op(lat);
    chk("t4_lat2", lat, 6);
    chk("t4_line_o", line_o, e);
    repeat (2) cyc();

    // Reset after two fill beats
    mp = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    c_rd = 1; c_raddr = 32'h0BAD_F00D;
    i = 0;
    while (!(m_kind == 1 && m_beats == 2) && i < 20) begin cyc(); i++; end
    chk("t5_reached_2_beats", i < 20, 1);
    rst = 1'b0; c_rd = 0; drop_kind = 0;
    cyc();
    rst = 1'b1;
    chk("t5_read_o", read_o, 0);
    chk("t5_resp_o", resp_o, 0);
    chk("t5_line_o", line_o, 0);
    mp.delete();
    cyc();
    e[0] = 64'hDEAD; e[1] = 64'hBEEF; e[2] = 64'hCAFE; e[3] = 64'hF00D;
    mp = '{1, 1, 1, 1};
    for (int j = 0; j < BEATS; j++) md.push_back(e[j]);
    c_rd = 1; c_raddr = 32'h0000_0040;
    run_op(lat);
    chk("t5_new_lat", lat, 5);
    chk("t5_new_line", line_o, e);
    repeat (2) cyc();

    // Random traffic: stray strobes, input changes after acceptance
    scramble = 1; stray = 1;
    for (int t = 0; t < 60; t++) begin
      int k;
      k = $urandom_range(0, 2);
      c_raddr = $urandom; c_waddr = $urandom; c_wline = rnd_line();
      if (k != 1) c_wr = 1;
      if (k != 0) c_rd = 1;
      i = 0;
      while ((c_rd || c_wr || m_kind != 0 || m_done) && i < 300) begin cyc(); i++; end
      chk("rand_op_done", i < 300, 1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
